// File: rtl/adc_sample_packer.sv
// Packs pairs of 4-channel 16-bit ADC sample sets into 128-bit DDR input FIFO words.
// Handles arming, threshold triggering, capture-length counting and overflow accounting.
module adc_sample_packer #(
  parameter int LEN_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             calib_done,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_mode,
  input  logic [15:0]      threshold,
  input  logic [LEN_W-1:0] capture_words,
  input  logic             s_valid,
  input  logic [63:0]      s_data,
  input  logic             ib_full,
  output logic             ib_we,
  output logic [127:0]     ib_wdata,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      overflow_cnt,
  output logic [LEN_W-1:0] words_done
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_mode;
  logic [15:0]      r_thresh;
  logic [LEN_W-1:0] r_len;
  logic             r_half;
  logic [63:0]      r_hold;
  logic             r_we;
  logic [127:0]     r_wdata;
  logic             r_done;
  logic             r_overflow;
  logic [15:0]      r_ovf_cnt;
  logic [LEN_W-1:0] r_words;

  logic [16:0]      w_abs;
  logic             w_trig;
  logic [LEN_W-1:0] w_words_inc;
  logic             w_arm_ok;
  logic             w_accept;
  logic             w_complete;
  logic             w_last;

  // 17-bit magnitude so that -32768 maps to 32768 rather than wrapping
  assign w_abs       = s_data[15] ? ({1'b0, ~s_data[15:0]} + 17'd1) : {1'b0, s_data[15:0]};
  assign w_trig      = !r_mode || (w_abs >= {1'b0, r_thresh});
  assign w_words_inc = r_words + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_arm_ok     = 1'b0;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_last       = 1'b0;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm && calib_done) begin
            w_arm_ok     = 1'b1;
            w_next_state = ARMED;
          end
        end
        ARMED: begin
          if (s_valid && w_trig) begin
            w_accept     = 1'b1;
            w_next_state = CAPTURE;
          end
        end
        CAPTURE: begin
          if (s_valid) begin
            w_accept = 1'b1;
            if (r_half) begin
              w_complete = 1'b1;
              if (w_words_inc == r_len) begin
                w_last       = 1'b1;
                w_next_state = IDLE;
              end
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Dropped words still advance the count so the capture window stays time-based
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= 1'b0;
      r_thresh   <= '0;
      r_len      <= '0;
      r_half     <= 1'b0;
      r_hold     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
      r_words    <= '0;
    end else begin
      r_we <= 1'b0;
      if (abort) begin
        r_half <= 1'b0;
        r_done <= 1'b0;
      end
      if (w_arm_ok) begin
        r_mode     <= trig_mode;
        r_thresh   <= threshold;
        r_len      <= (capture_words == '0) ? LEN_W'(1) : capture_words;
        r_half     <= 1'b0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
        r_ovf_cnt  <= '0;
        r_words    <= '0;
      end
      if (w_accept && !r_half) begin
        r_hold <= s_data;
        r_half <= 1'b1;
      end
      if (w_complete) begin
        r_half  <= 1'b0;
        r_words <= w_words_inc;
        if (!ib_full) begin
          r_we    <= 1'b1;
          r_wdata <= {s_data, r_hold};
        end else begin
          r_overflow <= 1'b1;
          if (r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
      end
      if (w_last) r_done <= 1'b1;
    end
  end

  assign ib_we        = r_we;
  assign ib_wdata     = r_wdata;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign overflow_cnt = r_ovf_cnt;
  assign words_done   = r_words;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed self-checking bench for adc_sample_packer: capture modes, overflow,
// abort, arm gating and asynchronous reset, with hand-computed expected words.
module tb_adc_sample_packer;

  localparam int LEN_W = 25;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             calib_done;
  logic             arm;
  logic             abort;
  logic             trig_mode;
  logic [15:0]      threshold;
  logic [LEN_W-1:0] capture_words;
  logic             s_valid;
  logic [63:0]      s_data;
  logic             ib_full;
  logic             ib_we;
  logic [127:0]     ib_wdata;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [15:0]      overflow_cnt;
  logic [LEN_W-1:0] words_done;

  int checkCount = 0;
  int errCount   = 0;
  logic [127:0] wordQ[$];
  int qSize;

  adc_sample_packer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .threshold(threshold), .capture_words(capture_words),
    .s_valid(s_valid), .s_data(s_data), .ib_full(ib_full), .ib_we(ib_we),
    .ib_wdata(ib_wdata), .busy(busy), .done(done), .overflow(overflow),
    .overflow_cnt(overflow_cnt), .words_done(words_done)
  );

  always #5 clk = ~clk;

  // Capture every FIFO write half a cycle after the strobe is launched
  always @(negedge clk) if (ib_we) wordQ.push_back(ib_wdata);

  function automatic logic [63:0] mkSet(input logic [15:0] ch0);
    mkSet = {ch0 + 16'h0300, ch0 + 16'h0200, ch0 + 16'h0100, ch0};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] ch0);
    s_valid = valid;
    s_data  = mkSet(ch0);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic doArm(input logic mode, input logic [15:0] thr, input logic [LEN_W-1:0] len);
    arm           = 1'b1;
    trig_mode     = mode;
    threshold     = thr;
    capture_words = len;
    tick();
    arm = 1'b0;
  endtask

  task automatic doAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; calib_done = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 1'b0;
    threshold = '0; capture_words = '0; s_valid = 1'b0; s_data = '0; ib_full = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checkOutput("rst_we", ib_we, 0);
    checkOutput("rst_wdata", ib_wdata, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_ovfcnt", overflow_cnt, 0);
    checkOutput("rst_words", words_done, 0);

    // Mode 0, 4 words; a set coinciding with arm must be ignored
    calib_done = 1'b1;
    s_valid = 1'b1; s_data = mkSet(16'h0055);
    doArm(1'b0, 16'h0000, 4);
    s_valid = 1'b0;
    checkOutput("m0_busy_arm", busy, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'(i));
    checkOutput("m0_last_we", ib_we, 1);
    checkOutput("m0_done", done, 1);
    checkOutput("m0_busy_end", busy, 0);
    applyStimulus(1'b1, 16'h0008);
    tick(); tick();
    checkOutput("m0_nwords", wordQ.size(), 4);
    checkOutput("m0_w0_lo", wordQ[0][15:0], 16'h0000);
    checkOutput("m0_w0_hi", wordQ[0][79:64], 16'h0001);
    checkOutput("m0_w3", wordQ[3], {mkSet(16'h0007), mkSet(16'h0006)});
    checkOutput("m0_words", words_done, 4);

    // Threshold trigger at |-1000| >= 1000
    wordQ.delete();
    doArm(1'b1, 16'd1000, 1);
    checkOutput("th_done_clr", done, 0);
    applyStimulus(1'b1, 16'd10);
    applyStimulus(1'b1, 16'hFC19);
    applyStimulus(1'b1, 16'hFC18);
    applyStimulus(1'b1, 16'd5);
    tick();
    checkOutput("th_nwords", wordQ.size(), 1);
    checkOutput("th_w0_lo", wordQ[0][15:0], 16'hFC18);
    checkOutput("th_w0_hi", wordQ[0][79:64], 16'h0005);
    checkOutput("th_done", done, 1);

    // -32768 has magnitude 32768, below 0xFFFF: no trigger
    wordQ.delete();
    doArm(1'b1, 16'hFFFF, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h8000);
    checkOutput("nt_busy", busy, 1);
    checkOutput("nt_words", words_done, 0);
    checkOutput("nt_nwords", wordQ.size(), 0);
    doAbort();
    checkOutput("nt_abort_busy", busy, 0);

    // Overflow: FIFO full while words 2 and 3 complete
    wordQ.delete();
    doArm(1'b0, 16'h0000, 6);
    for (int i = 0; i < 12; i++) begin
      ib_full = (i == 3) || (i == 5);
      applyStimulus(1'b1, 16'(i));
    end
    ib_full = 1'b0;
    tick();
    checkOutput("ov_nwords", wordQ.size(), 4);
    checkOutput("ov_flag", overflow, 1);
    checkOutput("ov_cnt", overflow_cnt, 2);
    checkOutput("ov_words", words_done, 6);
    checkOutput("ov_done", done, 1);
    checkOutput("ov_w1_lo", wordQ[1][15:0], 16'h0006);

    // Abort with a half-word held, then a fresh capture
    wordQ.delete();
    doArm(1'b0, 16'h0000, 4);
    checkOutput("ab_ovf_clr", overflow_cnt, 0);
    applyStimulus(1'b1, 16'h0010);
    applyStimulus(1'b1, 16'h0011);
    applyStimulus(1'b1, 16'h0012);
    doAbort();
    checkOutput("ab_busy", busy, 0);
    checkOutput("ab_done", done, 0);
    checkOutput("ab_words_hold", words_done, 1);
    wordQ.delete();
    doArm(1'b0, 16'h0000, 1);
    applyStimulus(1'b1, 16'h0020);
    applyStimulus(1'b1, 16'h0021);
    tick();
    checkOutput("ab_nwords", wordQ.size(), 1);
    checkOutput("ab_word", wordQ[0], {mkSet(16'h0021), mkSet(16'h0020)});

    // Arm gating by calibration and while capturing
    calib_done = 1'b0;
    doArm(1'b0, 16'h0000, 2);
    checkOutput("gt_nocal_busy", busy, 0);
    calib_done = 1'b1;
    doArm(1'b0, 16'h0000, 2);
    applyStimulus(1'b1, 16'h0030);
    arm = 1'b1; trig_mode = 1'b1; threshold = 16'hFFFF; capture_words = 1;
    applyStimulus(1'b1, 16'h0031);
    arm = 1'b0;
    checkOutput("gt_cap_busy", busy, 1);
    checkOutput("gt_cap_done", done, 0);
    checkOutput("gt_cap_words", words_done, 1);
    applyStimulus(1'b1, 16'h0032);
    applyStimulus(1'b1, 16'h0033);
    checkOutput("gt_end_done", done, 1);
    checkOutput("gt_end_words", words_done, 2);

    // Asynchronous reset between edges mid-capture
    doArm(1'b0, 16'h0000, 4);
    applyStimulus(1'b1, 16'h0040);
    applyStimulus(1'b1, 16'h0041);
    applyStimulus(1'b1, 16'h0042);
    s_valid = 1'b1; s_data = mkSet(16'h0043);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_words", words_done, 0);
    checkOutput("ar_wdata", ib_wdata, 0);
    checkOutput("ar_we", ib_we, 0);
    qSize = wordQ.size();
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 16'h0044);
    applyStimulus(1'b1, 16'h0045);
    tick(); tick();
    checkOutput("ar_no_we", wordQ.size(), qSize);
    checkOutput("ar_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
